// File: rtl/fsk_tx_pkg.sv
// Shared types, mode encodings and frequency/timing helpers for the FSK I/Q transmitter.
// Increments are in units of clk/256 (62.5 kHz at 16 MHz).
package fsk_tx_pkg;
   localparam int SPS_BLE = 16;
   localparam int SPS_154 = 8;

   typedef logic [1:0] mode_t;
   localparam mode_t MODE_BLE_2M25 = 2'd0;
   localparam mode_t MODE_154      = 2'd1;
   localparam mode_t MODE_BLE_1M75 = 2'd2;
   localparam mode_t MODE_BLE_1M25 = 2'd3;

   typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

   function automatic logic [7:0] tone_inc(input mode_t mode, input logic bit_v);
      logic [7:0] inc;
      case (mode)
         MODE_BLE_2M25: inc = bit_v ? 8'd40 : 8'd32;
         MODE_154:      inc = bit_v ? 8'd48 : 8'd32;
         MODE_BLE_1M75: inc = bit_v ? 8'd32 : 8'd24;
         default:       inc = bit_v ? 8'd24 : 8'd16;
      endcase
      return inc;
   endfunction

   // Last sample-counter value of a symbol.
   function automatic logic [3:0] sps_last(input mode_t mode);
      return (mode == MODE_154) ? 4'(SPS_154 - 1) : 4'(SPS_BLE - 1);
   endfunction
endpackage

// File: rtl/fsk_iq_tx_if.sv
// Byte-stream input handshake plus modulated I/Q sample output of the FSK transmitter.
interface fsk_iq_tx_if;
   logic [1:0]        select;
   logic [7:0]        data_in;
   logic              data_valid;
   logic              data_last;
   logic              data_ready;
   logic signed [3:0] I_out;
   logic signed [3:0] Q_out;
   logic              iq_valid;
   logic              bit_strobe;
   logic              tx_bit;
   logic              underrun;

   modport master (
      output select, data_in, data_valid, data_last,
      input  data_ready, I_out, Q_out, iq_valid, bit_strobe, tx_bit, underrun
   );
   modport slave (
      input  select, data_in, data_valid, data_last,
      output data_ready, I_out, Q_out, iq_valid, bit_strobe, tx_bit, underrun
   );
endinterface

// File: rtl/iq_sincos_lut.sv
// 32-point sin/cos table, amplitude AMP, rounded to nearest; purely combinational.
// Quarter-wave magnitudes are stored as Q15 sin values and scaled by AMP.
module iq_sincos_lut #(
   parameter int AMP = 7
) (
   input  logic [4:0]        idx,
   output logic signed [3:0] sin_out,
   output logic signed [3:0] cos_out
);
   function automatic logic signed [3:0] mag(input logic [3:0] r);
      int s;
      case (r)
         4'd0:    s = 0;
         4'd1:    s = 6393;
         4'd2:    s = 12540;
         4'd3:    s = 18205;
         4'd4:    s = 23170;
         4'd5:    s = 27246;
         4'd6:    s = 30274;
         4'd7:    s = 32138;
         default: s = 32768;
      endcase
      return 4'((AMP * s + 16384) >>> 15);
   endfunction

   function automatic logic signed [3:0] sin5(input logic [4:0] k);
      logic [3:0]        r;
      logic signed [3:0] m;
      r = k[3] ? (4'd8 - {1'b0, k[2:0]}) : {1'b0, k[2:0]};
      m = mag(r);
      return k[4] ? -m : m;
   endfunction

   always_comb begin
      sin_out = sin5(idx);
      cos_out = sin5(idx + 5'd8);
   end
endmodule

// File: rtl/fsk_iq_tx.sv
// Byte serializer + continuous-phase FSK modulator, one 4-bit I/Q sample per clk.
// First sample one edge after byte accept; data_ready only in IDLE and on a non-last byte's final sample.
module fsk_iq_tx
   import fsk_tx_pkg::*;
#(
   parameter int PHASE_W = 8,
   parameter int AMP     = 7
) (
   input logic        clk,
   input logic        rst,
   fsk_iq_tx_if.slave bus
);
   state_t                 state, state_nxt;
   logic [7:0]             byte_q, byte_n;
   logic                   last_q;
   mode_t                  mode_q, mode_n;
   logic [PHASE_W-1:0]     phase;
   logic [3:0]             cnt, cnt_n;
   logic [2:0]             bit_idx, bit_n;
   logic                   boundary, accept, tx_n, ready_nxt, underrun_c;
   logic signed [3:0]      lut_sin, lut_cos, i_q, q_q;
   logic                   iq_vld_q, strobe_q, tx_bit_q, ready_q;

   iq_sincos_lut #(.AMP(AMP)) u_lut (
      .idx     (phase[PHASE_W-1 -: 5]),
      .sin_out (lut_sin),
      .cos_out (lut_cos)
   );

   assign boundary = (state == SEND) && (bit_idx == 3'd7) && (cnt == sps_last(mode_q));
   assign accept   = bus.data_valid && ready_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SEND;
         SEND:    if (boundary && !accept) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      mode_n = (state == IDLE) ? bus.select : mode_q;
      byte_n = byte_q;
      cnt_n  = cnt + 4'd1;
      bit_n  = bit_idx;
      if (accept) begin
         byte_n = bus.data_in;
         cnt_n  = 4'd0;
         bit_n  = 3'd0;
      end else if (cnt == sps_last(mode_q)) begin
         cnt_n = 4'd0;
         bit_n = bit_idx + 3'd1;
      end
      tx_n       = byte_n[bit_n];
      underrun_c = boundary && !last_q && !bus.data_valid;
      // Ready is registered, so raise it on the edge that enters the final sample.
      ready_nxt  = (state_nxt == IDLE) ||
                   (!accept && !last_q && bit_n == 3'd7 && cnt_n == sps_last(mode_q));
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         byte_q   <= '0;
         last_q   <= 1'b0;
         mode_q   <= MODE_BLE_2M25;
         phase    <= '0;
         cnt      <= '0;
         bit_idx  <= '0;
         i_q      <= '0;
         q_q      <= '0;
         iq_vld_q <= 1'b0;
         strobe_q <= 1'b0;
         tx_bit_q <= 1'b0;
         ready_q  <= 1'b0;
      end else begin
         ready_q <= ready_nxt;
         if (state_nxt == SEND) begin
            if (accept) begin
               last_q <= bus.data_last;
               mode_q <= mode_n;
            end
            byte_q   <= byte_n;
            cnt      <= cnt_n;
            bit_idx  <= bit_n;
            i_q      <= lut_cos;
            q_q      <= lut_sin;
            iq_vld_q <= 1'b1;
            strobe_q <= (cnt_n == 4'd0);
            tx_bit_q <= tx_n;
            phase    <= phase + (PHASE_W'(tone_inc(mode_n, tx_n)) << (PHASE_W - 8));
         end else begin
            phase    <= '0;
            cnt      <= '0;
            bit_idx  <= '0;
            i_q      <= '0;
            q_q      <= '0;
            iq_vld_q <= 1'b0;
            strobe_q <= 1'b0;
            tx_bit_q <= 1'b0;
         end
      end
   end

   assign bus.data_ready = ready_q;
   assign bus.I_out      = i_q;
   assign bus.Q_out      = q_q;
   assign bus.iq_valid   = iq_vld_q;
   assign bus.bit_strobe = strobe_q;
   assign bus.tx_bit     = tx_bit_q;
   assign bus.underrun   = underrun_c;
endmodule

// File: tb/tb_fsk_iq_tx.sv
// Directed bench for fsk_iq_tx: table of single-byte packets plus back-to-back, underrun and reset sequences.
module tb_fsk_iq_tx;
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fsk_iq_tx_if bus();
   fsk_iq_tx dut (.clk(clk), .rst(rst), .bus(bus));

   int n_cmp = 0;
   int n_err = 0;

   int cap_i[1024], cap_q[1024], cap_tx[1024], cap_stb[1024], cap_rdy[1024], cap_und[1024];
   int n_cap;

   int inc0[4] = '{32, 32, 24, 16};
   int inc1[4] = '{40, 48, 32, 24};
   int sps_tb[4] = '{16, 8, 16, 16};

   typedef struct {
      int mode; int data; int probe;
      int exp_i; int exp_q; int exp_tx; int exp_len; int exp_stb;
   } vec_t;
   vec_t vecs[8];

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int ref_sin(input int k);
      real v;
      v = 7.0 * $sin(6.283185307179586 * k / 32.0);
      return $rtoi(v + ((v >= 0.0) ? 0.5 : -0.5));
   endfunction

   task automatic start_pkt(input int mode, input int data, input int last);
      int w = 0;
      while (!bus.data_ready && w < 20) begin
         tick();
         w++;
      end
      chk("ready_before_start", int'(bus.data_ready), 1);
      bus.select     = 2'(mode);
      bus.data_in    = 8'(data);
      bus.data_last  = last[0];
      bus.data_valid = 1'b1;
      tick();
      bus.data_valid = 1'b0;
   endtask

   // Record every valid sample; drop data_valid once a held byte is taken.
   task automatic capture();
      logic acc;
      n_cap = 0;
      while (bus.iq_valid && n_cap < 1000) begin
         cap_i[n_cap]   = int'(bus.I_out);
         cap_q[n_cap]   = int'(bus.Q_out);
         cap_tx[n_cap]  = int'(bus.tx_bit);
         cap_stb[n_cap] = int'(bus.bit_strobe);
         cap_rdy[n_cap] = int'(bus.data_ready);
         cap_und[n_cap] = int'(bus.underrun);
         acc = bus.data_valid && bus.data_ready;
         n_cap++;
         tick();
         if (acc) bus.data_valid = 1'b0;
      end
   endtask

   task automatic check_wave(input string name, input int mode, input int b0, input int b1, input int nbytes);
      int ph = 0;
      int idx = 0;
      int bad = 0;
      for (int b = 0; b < nbytes; b++) begin
         int byt = (b == 0) ? b0 : b1;
         for (int bi = 0; bi < 8; bi++) begin
            int bv = (byt >> bi) & 1;
            for (int s = 0; s < sps_tb[mode]; s++) begin
               if (idx >= n_cap) bad++;
               else if (cap_i[idx] != ref_sin((ph / 8 + 8) % 32) || cap_q[idx] != ref_sin(ph / 8) ||
                        cap_tx[idx] != bv || cap_stb[idx] != ((s == 0) ? 1 : 0)) bad++;
               ph = (ph + ((bv != 0) ? inc1[mode] : inc0[mode])) % 256;
               idx++;
            end
         end
      end
      chk(name, bad, 0);
   endtask

   function automatic int count(input int which);
      int c = 0;
      for (int k = 0; k < n_cap; k++)
         c += (which == 0) ? cap_stb[k] : (which == 1) ? cap_rdy[k] : cap_und[k];
      return c;
   endfunction

   initial begin
      int bits_got, bits_exp;
      vecs[0] = '{0, 'h01,  1,  4,  6, 1, 128, 8};
      vecs[1] = '{0, 'h01, 16, -7,  0, 0, 128, 8};
      vecs[2] = '{1, 'hFF,  1,  3,  6, 1,  64, 8};
      vecs[3] = '{1, 'hFF,  9, -3, -6, 1,  64, 8};
      vecs[4] = '{3, 'h00,  2,  5,  5, 0, 128, 8};
      vecs[5] = '{2, 'h00,  1,  6,  4, 0, 128, 8};
      vecs[6] = '{1, 'h00,  4, -7,  0, 0,  64, 8};
      vecs[7] = '{0, 'h00,  0,  7,  0, 0, 128, 8};

      bus.select = 2'd0; bus.data_in = 8'd0; bus.data_valid = 1'b0; bus.data_last = 1'b0;
      repeat (3) tick();
      chk("rst_ready", int'(bus.data_ready), 0);
      chk("rst_iq_valid", int'(bus.iq_valid), 0);
      chk("rst_I", int'(bus.I_out), 0);
      chk("rst_underrun", int'(bus.underrun), 0);
      rst = 1'b1;
      tick();
      chk("idle_ready", int'(bus.data_ready), 1);
      chk("idle_iq_valid", int'(bus.iq_valid), 0);

      for (int v = 0; v < 8; v++) begin
         start_pkt(vecs[v].mode, vecs[v].data, 1);
         chk($sformatf("v%0d_first_valid", v), int'(bus.iq_valid), 1);
         capture();
         chk($sformatf("v%0d_len", v), n_cap, vecs[v].exp_len);
         chk($sformatf("v%0d_strobes", v), count(0), vecs[v].exp_stb);
         chk($sformatf("v%0d_I", v), cap_i[vecs[v].probe], vecs[v].exp_i);
         chk($sformatf("v%0d_Q", v), cap_q[vecs[v].probe], vecs[v].exp_q);
         chk($sformatf("v%0d_tx", v), cap_tx[vecs[v].probe], vecs[v].exp_tx);
         chk($sformatf("v%0d_ready_inside", v), count(1), 0);
         check_wave($sformatf("v%0d_wave", v), vecs[v].mode, vecs[v].data, 0, 1);
         chk($sformatf("v%0d_idle_ready", v), int'(bus.data_ready), 1);
      end

      // Back-to-back bytes; second byte held valid early, select changed mid-packet.
      start_pkt(2, 'hAA, 0);
      bus.data_in = 8'h55; bus.data_last = 1'b1; bus.data_valid = 1'b1; bus.select = 2'd3;
      capture();
      chk("b2b_len", n_cap, 256);
      chk("b2b_ready_pulses", count(1), 1);
      chk("b2b_ready_at_127", cap_rdy[127], 1);
      bits_got = 0;
      bits_exp = 'h55AA;
      for (int b = 0; b < 16; b++) bits_got |= cap_tx[b * 16] << b;
      chk("b2b_tx_bits", bits_got, bits_exp);
      check_wave("b2b_wave", 2, 'hAA, 'h55, 2);

      // Underrun at the byte boundary.
      start_pkt(3, 'h0F, 0);
      capture();
      chk("und_len", n_cap, 128);
      chk("und_pulses", count(2), 1);
      chk("und_at_127", cap_und[127], 1);
      chk("und_idle_ready", int'(bus.data_ready), 1);
      chk("und_idle_underrun", int'(bus.underrun), 0);

      // Reset in the middle of a mode 0 byte.
      start_pkt(0, 'h01, 1);
      repeat (40) tick();
      chk("mid_sample40_I", int'(bus.I_out), -7);
      rst = 1'b0;
      #1;
      chk("mid_rst_iq_valid", int'(bus.iq_valid), 0);
      chk("mid_rst_I", int'(bus.I_out), 0);
      chk("mid_rst_Q", int'(bus.Q_out), 0);
      chk("mid_rst_ready", int'(bus.data_ready), 0);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      start_pkt(1, 'hFF, 1);
      capture();
      chk("post_rst_len", n_cap, 64);
      chk("post_rst_I1", cap_i[1], 3);
      chk("post_rst_Q1", cap_q[1], 6);
      check_wave("post_rst_wave", 1, 'hFF, 0, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
